// File: rtl/stack_bus_pkg.sv
// Shared definitions for the stack bus master.
// Holds the controller/stack addresses, the increment/decrement command bytes,
// the command op codes, the FSM state encodings and small address helpers.
package stack_bus_pkg;

  localparam logic [15:0] SP0_ADDR    = 16'hFC00;
  localparam logic [15:0] SP1_ADDR    = 16'hFC01;
  localparam logic [15:0] INCDEC_ADDR = 16'hFC02;
  localparam logic [15:0] ENA_ADDR    = 16'hFC03;
  localparam logic [15:0] STACK0_BASE = 16'hC000;
  localparam logic [15:0] STACK1_BASE = 16'hC800;

  // Bytes written to the inc/dec register: each one clears exactly one bit.
  localparam logic [7:0] INC0_BYTE = 8'hFE;
  localparam logic [7:0] INC1_BYTE = 8'hFD;
  localparam logic [7:0] DEC0_BYTE = 8'hFB;
  localparam logic [7:0] DEC1_BYTE = 8'hF7;

  localparam logic [2:0] OP_PUSH   = 3'd0;
  localparam logic [2:0] OP_POP    = 3'd1;
  localparam logic [2:0] OP_SET_SP = 3'd2;
  localparam logic [2:0] OP_GET_SP = 3'd3;
  localparam logic [2:0] OP_ENABLE = 3'd4;

  // Command sequencer states (top level).
  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_BUS1, ST_BUS2, ST_FINISH
  } state_t;

  // Phases of a single bus cycle (bus_cycle_gen).
  typedef enum logic [1:0] {
    PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD
  } phase_t;

  function automatic logic [15:0] stack_base(input logic sel);
    return sel ? STACK1_BASE : STACK0_BASE;
  endfunction

  function automatic logic [15:0] sp_addr(input logic sel);
    return sel ? SP1_ADDR : SP0_ADDR;
  endfunction

endpackage

// File: rtl/stack_bus_master_cycle.sv
// Single external bus cycle generator: SETUP, STROBE, HOLD.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         begin a cycle (taken when idle or in the final HOLD clock)
//   i_is_write      1 = write (n_we strobe, d_oe driven), 0 = read (n_oe strobe)
//   i_addr, i_data  address / write data latched at start
//   i_d_in          bus read data, captured on the last STROBE clock
//   o_a, o_d_out, o_d_oe, o_n_we, o_n_oe   registered bus outputs
//   o_busy          a cycle is in progress
//   o_last          high during the final HOLD clock (one-clock pulse)
//   o_rdata         last captured read data
module bus_cycle_gen
  import stack_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_is_write,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_d_in,
  output logic [15:0] o_a,
  output logic [7:0]  o_d_out,
  output logic        o_d_oe,
  output logic        o_n_we,
  output logic        o_n_oe,
  output logic        o_busy,
  output logic        o_last,
  output logic [7:0]  o_rdata
);

  localparam logic [7:0] L_SETUP  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] L_STROBE = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] L_HOLD   = 8'(HOLD_CYCLES - 1);

  phase_t     r_phase, w_phase_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_wr;
  logic       w_last, w_accept;

  assign w_last   = (r_phase == PH_HOLD) && (r_cnt == L_HOLD);
  // Accepting in the last HOLD clock gives back-to-back cycles with no gap.
  assign w_accept = i_start && ((r_phase == PH_IDLE) || w_last);

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt + 8'd1;
    case (r_phase)
      PH_IDLE:   w_cnt_nxt = '0;
      PH_SETUP:  if (r_cnt == L_SETUP)  begin w_phase_nxt = PH_STROBE; w_cnt_nxt = '0; end
      PH_STROBE: if (r_cnt == L_STROBE) begin w_phase_nxt = PH_HOLD;   w_cnt_nxt = '0; end
      PH_HOLD:   if (w_last)            begin w_phase_nxt = PH_IDLE;   w_cnt_nxt = '0; end
      default:   w_phase_nxt = PH_IDLE;
    endcase
    if (w_accept) begin
      w_phase_nxt = PH_SETUP;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      o_a     <= '0;
      o_d_out <= '0;
      o_d_oe  <= 1'b0;
      o_n_we  <= 1'b1;
      o_n_oe  <= 1'b1;
      o_rdata <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        o_a     <= i_addr;
        o_d_out <= i_data;
        o_d_oe  <= i_is_write;
        r_wr    <= i_is_write;
      end else if (w_last) begin
        o_d_oe  <= 1'b0;
      end
      // r_wr is stable whenever STROBE is next, so the strobes stay exclusive.
      o_n_we <= !((w_phase_nxt == PH_STROBE) && r_wr);
      o_n_oe <= !((w_phase_nxt == PH_STROBE) && !r_wr);
      if ((r_phase == PH_STROBE) && (r_cnt == L_STROBE) && !r_wr)
        o_rdata <= i_d_in;
    end
  end

  assign o_busy = (r_phase != PH_IDLE);
  assign o_last = w_last;

endmodule

// File: rtl/stack_bus_master.sv
// CPU-side initiator for the memory-mapped stack controller and stack bank.
// Decodes PUSH/POP/SET_SP/GET_SP/ENABLE into one or two bus cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, op, sel, wdata      command request (taken while ready=1)
//   ready, done, err, rdata  handshake and result
//   a, d_out, d_oe, d_in     bus address / data
//   n_we, n_oe               active-low write / read strobes
module stack_bus_master
  import stack_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic        sel,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        n_we,
  output logic        n_oe
);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_op;
  logic        r_sel;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        w_start, w_last, w_busy;
  logic        w_two, w_illegal, w_reads, w_is_write;
  logic [15:0] w_addr;
  logic [7:0]  w_data, w_cap;

  // Bus cycle description: LAUNCH issues the first cycle, BUS1 the second.
  always_comb begin
    w_two      = (r_op == OP_PUSH) || (r_op == OP_POP);
    w_illegal  = (r_op > OP_ENABLE);
    w_reads    = (r_op == OP_POP) || (r_op == OP_GET_SP);
    w_addr     = '0;
    w_data     = '0;
    w_is_write = 1'b1;
    if (r_state == ST_LAUNCH) begin
      case (r_op)
        OP_PUSH:   begin w_addr = stack_base(r_sel); w_data = r_wdata; end
        OP_POP:    begin w_addr = INCDEC_ADDR; w_data = r_sel ? DEC1_BYTE : DEC0_BYTE; end
        OP_SET_SP: begin w_addr = sp_addr(r_sel); w_data = r_wdata; end
        OP_GET_SP: begin w_addr = sp_addr(r_sel); w_is_write = 1'b0; end
        OP_ENABLE: begin w_addr = ENA_ADDR; w_data = {7'b0, r_wdata[0]}; end
        default:   ;
      endcase
    end else if (r_op == OP_PUSH) begin
      w_addr = INCDEC_ADDR;
      w_data = r_sel ? INC1_BYTE : INC0_BYTE;
    end else begin
      w_addr     = stack_base(r_sel);
      w_is_write = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE:   if (req) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        if (w_illegal) begin
          w_state_nxt = ST_FINISH;
        end else if (!w_busy) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BUS1;
        end
      end
      ST_BUS1: begin
        if (w_last) begin
          if (w_two) begin
            w_start     = 1'b1;
            w_state_nxt = ST_BUS2;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_BUS2:   if (w_last) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_last && (w_state_nxt == ST_FINISH) && w_reads)
        r_rdata <= w_cap;
    end
  end

  // Command fields are data: latched at acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && req) begin
      r_op    <= op;
      r_sel   <= sel;
      r_wdata <= wdata;
    end
  end

  bus_cycle_gen #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .STROBE_CYCLES(STROBE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_cycle (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_is_write(w_is_write),
    .i_addr    (w_addr),
    .i_data    (w_data),
    .i_d_in    (d_in),
    .o_a       (a),
    .o_d_out   (d_out),
    .o_d_oe    (d_oe),
    .o_n_we    (n_we),
    .o_n_oe    (n_oe),
    .o_busy    (w_busy),
    .o_last    (w_last),
    .o_rdata   (w_cap)
  );

  assign ready = (r_state == ST_IDLE);
  assign done  = (r_state == ST_FINISH);
  assign err   = (r_state == ST_FINISH) && w_illegal;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_stack_bus_master.sv
module tb_stack_bus_master;

  logic        clk = 1'b0;
  logic        rst, req, sel, ready, done, err, d_oe, n_we, n_oe;
  logic [2:0]  op;
  logic [7:0]  wdata, rdata, d_out, d_in;
  logic [15:0] a;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_rdata = 8'h00;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    int          len;
  } acc_t;

  always #5 clk = ~clk;

  stack_bus_master dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .sel(sel), .wdata(wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata), .a(a),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .n_we(n_we), .n_oe(n_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bus accesses, straight from the command definitions.
  task automatic expect_accesses(input logic [2:0] c_op, input logic c_sel,
                                 input logic [7:0] c_wd, output acc_t q[$]);
    logic [15:0] stk;
    q = {};
    stk = c_sel ? 16'hC800 : 16'hC000;
    case (c_op)
      3'd0: begin
        q.push_back('{stk, c_wd, 1'b1, 2});
        q.push_back('{16'hFC02, c_sel ? 8'hFD : 8'hFE, 1'b1, 2});
      end
      3'd1: begin
        q.push_back('{16'hFC02, c_sel ? 8'hF7 : 8'hFB, 1'b1, 2});
        q.push_back('{stk, 8'h00, 1'b0, 2});
      end
      3'd2: q.push_back('{16'hFC00 + {15'b0, c_sel}, c_wd, 1'b1, 2});
      3'd3: q.push_back('{16'hFC00 + {15'b0, c_sel}, 8'h00, 1'b0, 2});
      3'd4: q.push_back('{16'hFC03, {7'b0, c_wd[0]}, 1'b1, 2});
      default: ;
    endcase
  endtask

  task automatic run_cmd(input logic [2:0] c_op, input logic c_sel,
                         input logic [7:0] c_wd, input logic [7:0] c_din);
    acc_t exp_q[$];
    acc_t got_q[$];
    int done_k, n_done, exp_lat, n;
    logic prev_low;
    logic [15:0] cur_a;
    expect_accesses(c_op, c_sel, c_wd, exp_q);
    exp_lat = 1 + 4 * exp_q.size();
    if (c_op == 3'd1 || c_op == 3'd3) model_rdata = c_din;
    @(negedge clk);
    chk("ready_before", 32'(ready), 32'd1);
    req = 1'b1; op = c_op; sel = c_sel; wdata = c_wd; d_in = c_din;
    @(posedge clk); #1;
    req = 1'b0; op = 3'($urandom); sel = 1'($urandom); wdata = 8'($urandom);
    done_k = -1; n_done = 0; prev_low = 1'b0; cur_a = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) chk("ready_drop", 32'(ready), 32'd0);
      chk("strobe_excl", 32'(!n_we && !n_oe), 32'd0);
      if (!n_we || !n_oe) begin
        if (!prev_low) begin
          got_q.push_back('{a, d_out, !n_we, 1});
          cur_a = a;
        end else begin
          got_q[got_q.size()-1].len++;
          chk("a_stable", 32'(a), 32'(cur_a));
        end
        chk("d_oe_strobe", 32'(d_oe), 32'(!n_we));
        prev_low = 1'b1;
      end else begin
        prev_low = 1'b0;
      end
      if (done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          chk("err", 32'(err), 32'(c_op > 3'd4));
          chk("rdata", 32'(rdata), 32'(model_rdata));
        end
      end
      if (done_k >= 0 && k == done_k + 1) begin
        chk("ready_back", 32'(ready), 32'd1);
        chk("d_oe_idle", 32'(d_oe), 32'd0);
      end
    end
    chk("done_count", 32'(n_done), 32'd1);
    chk("latency", 32'(done_k), 32'(exp_lat));
    chk("n_access", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("acc_addr", 32'(got_q[i].addr), 32'(exp_q[i].addr));
      chk("acc_we", 32'(got_q[i].we), 32'(exp_q[i].we));
      chk("acc_len", 32'(got_q[i].len), 32'(exp_q[i].len));
      if (exp_q[i].we) chk("acc_data", 32'(got_q[i].data), 32'(exp_q[i].data));
    end
  endtask

  initial begin
    logic bad;
    rst = 1'b1; req = 1'b0; op = '0; sel = 1'b0; wdata = '0; d_in = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_n_we", 32'(n_we), 32'd1);
      chk("rst_n_oe", 32'(n_oe), 32'd1);
      chk("rst_d_oe", 32'(d_oe), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_d_out", 32'(d_out), 32'h0);
    rst = 1'b0;

    // Directed commands.
    run_cmd(3'd0, 1'b1, 8'h5A, 8'h00);
    run_cmd(3'd1, 1'b0, 8'h00, 8'h3C);
    run_cmd(3'd2, 1'b1, 8'h10, 8'h00);
    run_cmd(3'd3, 1'b1, 8'h00, 8'h10);
    run_cmd(3'd4, 1'b0, 8'hFF, 8'h00);
    run_cmd(3'd6, 1'b0, 8'h77, 8'h99);

    // Reset during the first STROBE clock of a PUSH.
    @(negedge clk);
    req = 1'b1; op = 3'd0; sel = 1'b0; wdata = 8'hA5;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!n_we) break;
    end
    chk("midrst_strobe", 32'(n_we), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = 8'h00;
    @(negedge clk);
    chk("midrst_n_we", 32'(n_we), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_a", 32'(a), 32'h0);
    chk("midrst_d_oe", 32'(d_oe), 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || !n_we || !n_oe || a == 16'hFC02) bad = 1'b1;
    end
    chk("midrst_quiet", 32'(bad), 32'd0);
    run_cmd(3'd0, 1'b0, 8'hC3, 8'h00);

    // Randomized commands, including illegal op codes.
    for (int i = 0; i < 30; i++)
      run_cmd(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
